cfg_dump_uart_tx: RTL and testbench

Read-back transmitter for the channel configuration memory. On a start pulse it walks the configuration byte array in ascending address order and serializes each byte as a UART 8N1 frame on tx. The host uses it to verify what the UART Rx / RAM write path actually stored. It sits beside the RAM block, drives its read address and consumes its registered read data.

---
 rtl/cfg_dump_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_cfg_dump_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_dump_uart_tx.sv
// Purpose : dumps the channel configuration memory as UART 8N1 frames, ascending address order.
// Latency : tx falls 2 clocks after start is accepted; each byte takes 10*CLK_DIV clocks plus a 2-clock gap.
// Backpressure: none; start is ignored while busy and on the done cycle.
// Ports   : clk_TX clock, rst sync active-high reset, start dump request,
//           r_addr/r_data memory read port (registered read data, one clock latency),
//           tx serial line (idle high), busy dump in progress, done one-cycle completion pulse.
// Option  : define CFG_DUMP_CHECKSUM_EN to append an XOR-of-all-bytes frame after the last byte.
module cfg_dump_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FRAME_LEN  = 112,
  parameter int START_ADDR = 0
) (
  input  logic       clk_TX,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] r_addr,
  input  logic [7:0] r_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  localparam int             BW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]  BAUD_TOP  = BW'(CLK_DIV - 1);
  localparam logic [7:0]     ADDR0     = 8'(START_ADDR);
  localparam int             LAST_IDX  = (FRAME_LEN > 0) ? FRAME_LEN - 1 : 0;
  localparam logic [7:0]     LAST_BYTE = 8'(LAST_IDX);

  state_t        state;
  logic [BW-1:0] baud;
  logic [7:0]    byte_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef CFG_DUMP_CHECKSUM_EN
  logic [7:0]    csum_acc;
  logic          csum_phase;  // set while the trailing checksum frame is in flight
`endif

  always_ff @(posedge clk_TX) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_addr   <= ADDR0;
      byte_cnt <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef CFG_DUMP_CHECKSUM_EN
      csum_acc   <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= ADDR0;
            byte_cnt <= '0;
`ifdef CFG_DUMP_CHECKSUM_EN
            // An empty dump still sends the (zero) checksum frame.
            csum_acc   <= '0;
            csum_phase <= (FRAME_LEN == 0);
            busy       <= 1'b1;
            state      <= S_FETCH;
`else
            if (FRAME_LEN == 0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_FETCH;
            end
`endif
          end
        end

        // r_addr is already valid; this cycle covers the RAM's registered read.
        S_FETCH: state <= S_LOAD;

        S_LOAD: begin
`ifdef CFG_DUMP_CHECKSUM_EN
          if (csum_phase) begin
            shreg <= csum_acc;
          end else begin
            shreg    <= r_data;
            csum_acc <= csum_acc ^ r_data;
          end
`else
          shreg <= r_data;
`endif
          tx    <= 1'b0;
          baud  <= BAUD_TOP;
          state <= S_START;
        end

        S_START: begin
          if (baud == '0) begin
            tx      <= shreg[0];
            baud    <= BAUD_TOP;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end

        S_DATA: begin
          if (baud == '0) begin
            baud <= BAUD_TOP;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              // shreg[0] is on the line; present the next bit and shift.
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end

        S_STOP: begin
          if (baud == '0) begin
`ifdef CFG_DUMP_CHECKSUM_EN
            if (csum_phase) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              tx         <= 1'b1;
              r_addr     <= ADDR0;
              csum_phase <= 1'b0;
              state      <= S_DONE;
            end else if (byte_cnt == LAST_BYTE) begin
              // Checksum frame reuses the FETCH/LOAD gap; address is left alone.
              csum_phase <= 1'b1;
              state      <= S_FETCH;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              r_addr   <= r_addr + 1'b1;
              state    <= S_FETCH;
            end
`else
            if (byte_cnt == LAST_BYTE) begin
              done   <= 1'b1;
              busy   <= 1'b0;
              tx     <= 1'b1;
              r_addr <= ADDR0;
              state  <= S_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              r_addr   <= r_addr + 1'b1;  // wraps modulo 256
              state    <= S_FETCH;
            end
`endif
          end else begin
            baud <= baud - 1'b1;
          end
        end

        // done was raised on entry; a start seen here is dropped.
        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_dump_uart_tx.sv
// Purpose : self-checking bench for cfg_dump_uart_tx with several parameterisations side by side.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_cfg_dump_uart_tx;
  localparam int CD = 4;
`ifdef CFG_DUMP_CHECKSUM_EN
  localparam int DK = 84;  // done offset for one data byte plus checksum frame
`else
  localparam int DK = 42;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_drv;
  int         sel;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_a, start_b, start_c, start_d;
  logic [7:0] addr_a, addr_b, addr_c, addr_d;
  logic [7:0] data_a, data_b, data_c, data_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  logic [7:0] mem_d [256];

  assign start_a = start_drv && (sel == 0);
  assign start_b = start_drv && (sel == 1);
  assign start_c = start_drv && (sel == 2);
  assign start_d = start_drv && (sel == 3);

  // Registered-read RAM models.
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
    data_c <= mem_c[addr_c];
    data_d <= mem_d[addr_d];
  end

  cfg_dump_uart_tx #(.CLK_DIV(CD), .FRAME_LEN(112), .START_ADDR(0)) u_a (
    .clk_TX(clk), .rst(rst), .start(start_a), .r_addr(addr_a), .r_data(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));
  cfg_dump_uart_tx #(.CLK_DIV(CD), .FRAME_LEN(1), .START_ADDR(0)) u_b (
    .clk_TX(clk), .rst(rst), .start(start_b), .r_addr(addr_b), .r_data(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));
  cfg_dump_uart_tx #(.CLK_DIV(CD), .FRAME_LEN(10), .START_ADDR(250)) u_c (
    .clk_TX(clk), .rst(rst), .start(start_c), .r_addr(addr_c), .r_data(data_c),
    .tx(tx_c), .busy(busy_c), .done(done_c));
  cfg_dump_uart_tx #(.CLK_DIV(CD), .FRAME_LEN(3), .START_ADDR(0)) u_d (
    .clk_TX(clk), .rst(rst), .start(start_d), .r_addr(addr_d), .r_data(data_d),
    .tx(tx_d), .busy(busy_d), .done(done_d));

  logic       mon_tx, mon_busy, mon_done;
  logic [7:0] mon_addr;
  always_comb begin
    mon_tx = tx_a; mon_busy = busy_a; mon_done = done_a; mon_addr = addr_a;
    case (sel)
      1: begin mon_tx = tx_b; mon_busy = busy_b; mon_done = done_b; mon_addr = addr_b; end
      2: begin mon_tx = tx_c; mon_busy = busy_c; mon_done = done_c; mon_addr = addr_c; end
      3: begin mon_tx = tx_d; mon_busy = busy_d; mon_done = done_d; mon_addr = addr_d; end
      default: ;
    endcase
  end

  // ---------------- UART monitor ----------------
  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic [7:0] exp_q [$];
  logic [7:0] addr_log [$];
  logic       prev_tx = 1'b1;
  bit         in_frame = 1'b0;
  int         mcnt = 0;
  int         frame_err = 0;
  logic [7:0] msh;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (prev_tx === 1'b1 && mon_tx === 1'b0) begin
        in_frame = 1'b1;
        mcnt = 0;
        msh = 8'h00;
        rx_t.push_back(cyc);
      end
    end else begin
      mcnt++;
      if (mcnt == CD / 2 && mon_tx !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++)
        if (mcnt == CD * (i + 1) + CD / 2) msh[i] = mon_tx;
      if (mcnt == CD * 9 + CD / 2) begin
        if (mon_tx !== 1'b1) frame_err++;
        rx_q.push_back(msh);
        in_frame = 1'b0;
      end
    end
    prev_tx = mon_tx;
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_mon();
    rx_q.delete(); rx_t.delete(); addr_log.delete(); exp_q.delete();
    frame_err = 0;
  endtask

  // Pulses start (sampled on the next edge) and leaves us at the first sample after it.
  task automatic pulse_start();
    @(negedge clk) start_drv = 1'b1;
    @(negedge clk) start_drv = 1'b0;
  endtask

  // Runs until done plus a short tail; optionally re-pulses start mid-dump.
  task automatic run_to_done(input int restart_at, output int dn);
    int post;
    dn = 0;
    post = 0;
    for (int c = 0; c < 8000 && post < 20; c++) begin
      if (mon_busy === 1'b1 && (addr_log.size() == 0 || mon_addr != addr_log[$]))
        addr_log.push_back(mon_addr);
      if (mon_done === 1'b1) dn++;
      if (dn > 0) post++;
      if (c == restart_at) check("busy_at_ignored_start", mon_busy, 1);
      @(negedge clk) start_drv = (c + 1 == restart_at);
    end
    start_drv = 1'b0;
  endtask

  task automatic check_rx(input string nm);
    int bad = 0;
    int gap_bad = 0;
    check({nm, "_frames"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    check({nm, "_bytes_wrong"}, bad, 0);
    for (int i = 1; i < rx_t.size(); i++)
      if (rx_t[i] - rx_t[i-1] != 10 * CD + 2) gap_bad++;
    check({nm, "_gaps_wrong"}, gap_bad, 0);
    check({nm, "_framing_errs"}, frame_err, 0);
  endtask

  // Appends the XOR of the expected bytes when the checksum build is active.
  task automatic add_csum();
`ifdef CFG_DUMP_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  typedef struct {
    int   k;
    logic tx;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl [19];

  initial begin
    int dn;
    int act;
    rst = 1'b1;
    start_drv = 1'b0;
    sel = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'h00;
      mem_c[i] = 8'(i) ^ 8'h5A;
      mem_d[i] = 8'h00;
    end
    mem_b[0] = 8'hA5;
    mem_d[0] = 8'h12; mem_d[1] = 8'h34; mem_d[2] = 8'h56;

    // Single byte 0xA5, LSB first: 1,0,1,0,0,1,0,1. k = samples after the start edge.
    tbl[0]  = '{0,  1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{5,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{6,  1'b1, 1'b1, 1'b0};
    tbl[5]  = '{9,  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{10, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{14, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{18, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{22, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{26, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{30, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{34, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{37, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{38, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{41, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{DK - 1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{DK,     1'b1, 1'b0, 1'b1};
    tbl[18] = '{DK + 1, 1'b1, 1'b0, 1'b0};

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_tx",   tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_addr_wrap_inst", addr_c, 250);
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if ((busy_a | busy_b | busy_c | busy_d | done_a | done_b | done_c | done_d) !== 1'b0 ||
          (tx_a & tx_b & tx_c & tx_d) !== 1'b1) act++;
    end
    check("idle_activity", act, 0);

    // ---- single byte, table driven ----
    sel = 1;
    clear_mon();
    pulse_start();
    for (int k = 0; k <= DK + 1; k++) begin
      for (int v = 0; v < 19; v++) begin
        if (tbl[v].k == k) begin
          check($sformatf("single_k%0d_tx", k),   tx_b,   int'(tbl[v].tx));
          check($sformatf("single_k%0d_busy", k), busy_b, int'(tbl[v].busy));
          check($sformatf("single_k%0d_done", k), done_b, int'(tbl[v].done));
        end
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    exp_q.push_back(8'hA5);
    add_csum();
    check_rx("single");

    // ---- full dump with an ignored second start ----
    sel = 0;
    clear_mon();
    pulse_start();
    run_to_done(500, dn);
    check("full_done_pulses", dn, 1);
    for (int i = 0; i < 112; i++) exp_q.push_back(8'(i));
    add_csum();
    check_rx("full");

    // ---- address wrap ----
    sel = 2;
    clear_mon();
    pulse_start();
    run_to_done(-1, dn);
    check("wrap_done_pulses", dn, 1);
    check("wrap_addr_count", addr_log.size(), 10);
    act = 0;
    for (int i = 0; i < addr_log.size() && i < 10; i++)
      if (addr_log[i] !== 8'(250 + i)) act++;
    check("wrap_addr_wrong", act, 0);
    check("wrap_addr_after_done", addr_c, 250);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(250 + i) ^ 8'h5A);
    add_csum();
    check_rx("wrap");

    // ---- reset during DATA of byte 5 ----
    sel = 0;
    clear_mon();
    pulse_start();
    repeat (225) @(negedge clk);  // byte 5 data bits span samples 216..247
    check("mid_busy_before_rst", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx",   tx_a, 1);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_addr", addr_a, 0);
    rst = 1'b0;
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_a === 1'b1 || tx_a !== 1'b1) dn++;
    end
    check("mid_rst_quiet", dn, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
    check("mid_rst_frames", rx_q.size(), 5);
    act = 0;
    for (int i = 0; i < 5 && i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) act++;
    check("mid_rst_bytes_wrong", act, 0);

    clear_mon();
    pulse_start();
    check("restart_addr", addr_a, 0);
    run_to_done(-1, dn);
    check("restart_done_pulses", dn, 1);
    for (int i = 0; i < 112; i++) exp_q.push_back(8'(i));
    add_csum();
    check_rx("restart");

`ifdef CFG_DUMP_CHECKSUM_EN
    // ---- checksum frame: 0x12 ^ 0x34 ^ 0x56 = 0x70 ----
    sel = 3;
    clear_mon();
    pulse_start();
    run_to_done(-1, dn);
    check("csum_done_pulses", dn, 1);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h70);
    check_rx("csum");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
